alu_muldiv: RTL

- Parametrised, multi-cycle successor of the single-cycle execute ALU.
- Keeps every existing ALUOp function at WIDTH bits.
- Adds the MIPS multiply/divide unit with architectural HI/LO registers, a valid/ready handshake and an overflow flag.
- Sits in the EX stage. The pipeline stalls on in_ready low and consumes the result on out_valid.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/muldiv_iter.sv | 104 ++++++++++
 rtl/alu_muldiv.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU with multiply/divide unit:
// op codes, FSM states and the signed-overflow helper.
package alu_pkg;

    localparam logic [4:0] OP_ADD   = 5'b00001;
    localparam logic [4:0] OP_SUB   = 5'b00010;
    localparam logic [4:0] OP_AND   = 5'b00011;
    localparam logic [4:0] OP_OR    = 5'b00100;
    localparam logic [4:0] OP_NOR   = 5'b00101;
    localparam logic [4:0] OP_SLT   = 5'b00110;
    localparam logic [4:0] OP_SLL   = 5'b00111;
    localparam logic [4:0] OP_SRL   = 5'b01000;
    localparam logic [4:0] OP_SRA   = 5'b01001;
    localparam logic [4:0] OP_ADDU  = 5'b01010;
    localparam logic [4:0] OP_SUBU  = 5'b01011;
    localparam logic [4:0] OP_LUI   = 5'b01111;
    localparam logic [4:0] OP_MULT  = 5'b10000;
    localparam logic [4:0] OP_MULTU = 5'b10001;
    localparam logic [4:0] OP_DIV   = 5'b10010;
    localparam logic [4:0] OP_DIVU  = 5'b10011;
    localparam logic [4:0] OP_MFHI  = 5'b10100;
    localparam logic [4:0] OP_MFLO  = 5'b10101;
    localparam logic [4:0] OP_MTHI  = 5'b10110;
    localparam logic [4:0] OP_MTLO  = 5'b10111;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

    // Subtraction is an addition of the inverted operand, so flip b's sign.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic r_msb, input logic is_sub);
        logic b_eff;
        b_eff = b_msb ^ is_sub;
        return (a_msb == b_eff) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative radix-2 shift-add multiplier / restoring divider on magnitudes.
// done is high during the final iteration; res_hi/res_lo are then the sign-fixed results.
module muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic             busy_q;
    logic [SHW-1:0]   cnt_q;
    logic             is_div_q;
    logic             neg_q;
    logic             rem_neg_q;
    logic             dz_q;
    logic [WIDTH-1:0] acc_hi_q;
    logic [WIDTH-1:0] acc_lo_q;
    logic [WIDTH-1:0] b_q;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_shift, div_trial;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] prod, prod_fix;

    always_comb begin
        a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
        b_mag = (is_signed && b[WIDTH-1]) ? -b : b;
    end

    // acc_hi holds the partial product / running remainder; acc_lo the multiplier / dividend.
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, b_q};
        if (is_div_q) begin
            if (!div_trial[WIDTH]) begin
                step_hi = div_trial[WIDTH-1:0];
                step_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod     = {step_hi, step_lo};
        prod_fix = neg_q ? -prod : prod;
        if (is_div_q) begin
            res_lo = dz_q ? {WIDTH{1'b1}} : (neg_q ? -step_lo : step_lo);
            res_hi = rem_neg_q ? -step_hi : step_hi;
        end else begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end
    end

    assign done = busy_q && (cnt_q == SHW'(WIDTH-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            b_q       <= '0;
        end else if (start) begin
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            is_div_q  <= is_div;
            neg_q     <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            rem_neg_q <= is_signed & a[WIDTH-1];
            dz_q      <= (b == '0);
            acc_hi_q  <= '0;
            acc_lo_q  <= a_mag;
            b_q       <= b_mag;
        end else if (busy_q) begin
            acc_hi_q <= step_hi;
            acc_lo_q <= step_lo;
            cnt_q    <= cnt_q + 1'b1;
            if (abort || done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// EX-stage ALU: single-cycle legacy ALUOp functions plus a multi-cycle
// MIPS multiply/divide unit with architectural HI/LO and valid/ready handshake.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic [SHW-1:0]   shamt,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             ovf_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             accept;
    logic             iter_start;
    logic             iter_done;
    logic [WIDTH-1:0] iter_hi, iter_lo;
    logic [WIDTH-1:0] sum, diff;
    logic [WIDTH-1:0] legacy_res;
    logic             legacy_ovf;

    assign accept     = in_valid && in_ready_q;
    assign iter_start = accept && (op == OP_MULT || op == OP_MULTU ||
                                   op == OP_DIV  || op == OP_DIVU);

    always_comb begin
        sum        = rs + rt;
        diff       = rs - rt;
        legacy_res = '0;
        legacy_ovf = 1'b0;
        case (op)
            OP_ADD: begin
                legacy_res = sum;
                legacy_ovf = signed_ovf(rs[WIDTH-1], rt[WIDTH-1], sum[WIDTH-1], 1'b0);
            end
            OP_SUB: begin
                legacy_res = diff;
                legacy_ovf = signed_ovf(rs[WIDTH-1], rt[WIDTH-1], diff[WIDTH-1], 1'b1);
            end
            OP_ADDU: legacy_res = sum;
            OP_SUBU: legacy_res = diff;
            OP_AND:  legacy_res = rs & rt;
            OP_OR:   legacy_res = rs | rt;
            OP_NOR:  legacy_res = ~(rs | rt);
            OP_SLT:  legacy_res = {{(WIDTH-1){1'b0}}, ($signed(rs) < $signed(rt))};
            OP_SLL:  legacy_res = rt << shamt;
            OP_SRL:  legacy_res = rt >> shamt;
            OP_SRA:  legacy_res = $unsigned($signed(rt) >>> shamt);
            OP_LUI:  legacy_res = rt << (WIDTH/2);
            default: legacy_res = '0;
        endcase
    end

    muldiv_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (iter_start),
        .abort     (flush),
        .is_div    (op[1]),
        .is_signed (~op[0]),
        .a         (rs),
        .b         (rt),
        .done      (iter_done),
        .res_hi    (iter_hi),
        .res_lo    (iter_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (!op[4]) begin
                            out_valid_q <= 1'b1;
                            result_q    <= legacy_res;
                            ovf_q       <= legacy_ovf;
                        end else begin
                            ovf_q <= 1'b0;
                            case (op)
                                OP_MULT, OP_MULTU: begin
                                    state_q    <= MUL;
                                    in_ready_q <= 1'b0;
                                end
                                OP_DIV, OP_DIVU: begin
                                    state_q    <= DIV;
                                    in_ready_q <= 1'b0;
                                end
                                OP_MFHI: begin
                                    out_valid_q <= 1'b1;
                                    result_q    <= hi_q;
                                end
                                OP_MFLO: begin
                                    out_valid_q <= 1'b1;
                                    result_q    <= lo_q;
                                end
                                OP_MTHI: begin
                                    out_valid_q <= 1'b1;
                                    result_q    <= '0;
                                    hi_q        <= rs;
                                end
                                OP_MTLO: begin
                                    out_valid_q <= 1'b1;
                                    result_q    <= '0;
                                    lo_q        <= rs;
                                end
                                default: begin
                                    out_valid_q <= 1'b1;
                                    result_q    <= '0;
                                end
                            endcase
                        end
                    end
                end
                MUL, DIV: begin
                    // An abort must leave HI/LO untouched, so it wins over completion.
                    if (flush) begin
                        state_q    <= IDLE;
                        in_ready_q <= 1'b1;
                    end else if (iter_done) begin
                        state_q     <= DONE;
                        hi_q        <= iter_hi;
                        lo_q        <= iter_lo;
                        result_q    <= iter_lo;
                        ovf_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign ovf       = ovf_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule
